// File: rtl/draw_sched.sv
// draw_sched: runs one drawing pass on the VGA adapter.
// A pass clears the screen with the fillscreen engine, then draws the circle
// with the circle engine. Whichever engine is active gets the single VGA pixel port.
//
// Handshake (both sides): a start level is raised and held until done is seen.
// done is then held until start falls. On the engine side the scheduler drops
// fs_start/c_start as soon as the engine's done is seen. It then waits for that
// done to fall before it moves on.
module draw_sched #(
  parameter logic [2:0]  BG_COLOUR      = 3'd0,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       err,
  output logic       fs_start,
  output logic [2:0] fs_colour,
  input  logic       fs_done,
  input  logic [7:0] fs_x,
  input  logic [6:0] fs_y,
  input  logic       fs_plot,
  output logic       c_start,
  output logic [2:0] c_colour,
  output logic [7:0] c_cx,
  output logic [6:0] c_cy,
  output logic [7:0] c_r,
  input  logic       c_done,
  input  logic [7:0] c_x,
  input  logic [6:0] c_y,
  input  logic [2:0] c_colour_px,
  input  logic       c_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_FILL_REL = 3'd2;
  localparam logic [2:0] S_CIRC     = 3'd3;
  localparam logic [2:0] S_CIRC_REL = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Last watchdog count before an engine is aborted
  localparam logic [19:0] TO_LAST = TIMEOUT_CYCLES - 20'd1;

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        fs_start_q, fs_start_d;
  logic        c_start_q, c_start_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  r_q, r_d;

  // Next-state, argument latch and watchdog logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = colour;
          cx_d    = centre_x;
          cy_d    = centre_y;
          r_d     = radius;
          err_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // A done arriving on the last count still counts as a normal finish
        if (fs_done) begin
          state_d = S_FILL_REL;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_FILL_REL: begin
        if (!fs_done) state_d = S_CIRC;
      end
      S_CIRC: begin
        if (c_done) begin
          state_d = S_CIRC_REL;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CIRC_REL: begin
        if (!c_done) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The watchdog restarts on every state entry and only runs while an engine works
    if (state_d != state_q) begin
      cnt_d = 20'd0;
    end else if ((state_q == S_FILL) || (state_q == S_CIRC)) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // The handshake outputs are registered from the next state so that they line up with state_q
    fs_start_d = (state_d == S_FILL);
    c_start_d  = (state_d == S_CIRC);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 20'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fs_start_q <= 1'b0;
      c_start_q  <= 1'b0;
      col_q      <= 3'd0;
      cx_q       <= 8'd0;
      cy_q       <= 7'd0;
      r_q        <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      fs_start_q <= fs_start_d;
      c_start_q  <= c_start_d;
      col_q      <= col_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      r_q        <= r_d;
    end
  end

  // Grant the pixel port by state; a plot from an engine without the grant is dropped
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    case (state_q)
      S_FILL, S_FILL_REL: begin
        vga_x      = fs_x;
        vga_y      = fs_y;
        vga_colour = BG_COLOUR;
        vga_plot   = fs_plot;
      end
      S_CIRC, S_CIRC_REL: begin
        vga_x      = c_x;
        vga_y      = c_y;
        vga_colour = c_colour_px;
        vga_plot   = c_plot;
      end
      default: begin
        vga_plot = 1'b0;
      end
    endcase
  end

  assign done      = done_q;
  assign err       = err_q;
  assign fs_start  = fs_start_q;
  assign fs_colour = BG_COLOUR;
  assign c_start   = c_start_q;
  assign c_colour  = col_q;
  assign c_cx      = cx_q;
  assign c_cy      = cy_q;
  assign c_r       = r_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_draw_sched.sv
// tb_draw_sched: randomized passes of the drawing scheduler, checked against rules
// written out in the bench (cycle counts, latched arguments, pixel grant).
module tb_draw_sched;

  localparam logic [2:0] BG  = 3'd5;
  localparam int         TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic       done, err, fs_start, c_start, vga_plot;
  logic [2:0] fs_colour, c_colour, vga_colour, dbg_state;
  logic       fs_done = 1'b0;
  logic [7:0] fs_x = '0;
  logic [6:0] fs_y = '0;
  logic       fs_plot = 1'b0;
  logic [7:0] c_cx, c_r, vga_x;
  logic [6:0] c_cy, vga_y;
  logic       c_done = 1'b0;
  logic [7:0] c_x = '0;
  logic [6:0] c_y = '0;
  logic [2:0] c_colour_px = '0;
  logic       c_plot = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Arguments accepted at the start of a pass, expected later on the circle port
  logic [25:0] exp_q[$];

  draw_sched #(.BG_COLOUR(BG), .TIMEOUT_CYCLES(20'(TMO))) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .done(done), .err(err), .fs_start(fs_start), .fs_colour(fs_colour),
    .fs_done(fs_done), .fs_x(fs_x), .fs_y(fs_y), .fs_plot(fs_plot),
    .c_start(c_start), .c_colour(c_colour), .c_cx(c_cx), .c_cy(c_cy), .c_r(c_r),
    .c_done(c_done), .c_x(c_x), .c_y(c_y), .c_colour_px(c_colour_px), .c_plot(c_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Move to just after the next rising edge; inputs are driven and outputs sampled there
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The two engine starts must never overlap
  always @(posedge clk) begin
    #2;
    if (rst_n && fs_start && c_start) chk("start_overlap", 32'(fs_start & c_start), 32'd0);
  end

  // Fill-phase pixel grant: only the fillscreen pixel gets through, in the background colour
  task automatic plot_fill();
    logic [7:0] x; logic [6:0] y;
    x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
    fs_x = x; fs_y = y; fs_plot = 1'b1;
    c_x = ~x; c_y = ~y; c_colour_px = ~BG; c_plot = 1'b1;
    #1;
    chk("fill_plot", 32'(vga_plot), 32'd1);
    chk("fill_x", 32'(vga_x), 32'(x));
    chk("fill_y", 32'(vga_y), 32'(y));
    chk("fill_col", 32'(vga_colour), 32'(BG));
    fs_plot = 1'b0;
    #1;
    chk("fill_cplot_drop", 32'(vga_plot), 32'd0);
    c_plot = 1'b0;
  endtask

  // Circle-phase pixel grant: only the circle pixel gets through, in its own colour
  task automatic plot_circ();
    logic [7:0] x; logic [6:0] y; logic [2:0] c;
    x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
    c = 3'($urandom_range(0, 7));
    c_x = x; c_y = y; c_colour_px = c; c_plot = 1'b1;
    fs_x = ~x; fs_y = ~y; fs_plot = 1'b1;
    #1;
    chk("circ_plot", 32'(vga_plot), 32'd1);
    chk("circ_x", 32'(vga_x), 32'(x));
    chk("circ_y", 32'(vga_y), 32'(y));
    chk("circ_col", 32'(vga_colour), 32'(c));
    c_plot = 1'b0;
    #1;
    chk("circ_fsplot_drop", 32'(vga_plot), 32'd0);
    fs_plot = 1'b0;
  endtask

  task automatic accept(input logic [2:0] col, input logic [7:0] cx,
                        input logic [6:0] cy, input logic [7:0] r, input bit push);
    colour = col; centre_x = cx; centre_y = cy; radius = r; start = 1'b1;
    if (push) exp_q.push_back({col, cx, cy, r});
    tick();
    chk("fs_start_rise", 32'(fs_start), 32'd1);
    chk("c_start_idle", 32'(c_start), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("fs_colour", 32'(fs_colour), 32'(BG));
  endtask

  // One complete pass: lf/lc are engine busy cycles, hf/hc how long the engine holds done
  task automatic run_pass(input logic [2:0] col, input logic [7:0] cx, input logic [6:0] cy,
                          input logic [7:0] r, input int lf, input int lc, input int hf,
                          input int hc, input bit drop_early, input bit scramble,
                          input int hold_done);
    logic [25:0] e;
    accept(col, cx, cy, r, 1'b1);
    if (scramble) begin
      colour = ~col; centre_x = ~cx; centre_y = ~cy; radius = 8'd99;
    end
    plot_fill();
    for (int i = 0; i < lf; i++) begin
      tick();
      chk("fs_start_hold", 32'(fs_start), 32'd1);
    end
    fs_done = 1'b1;
    tick();
    chk("fs_start_drop", 32'(fs_start), 32'd0);
    chk("c_start_wait", 32'(c_start), 32'd0);
    for (int i = 0; i < hf; i++) begin
      tick();
      chk("c_start_relwait", 32'(c_start), 32'd0);
    end
    fs_done = 1'b0;
    tick();
    chk("c_start_rise", 32'(c_start), 32'd1);
    chk("fs_start_circ", 32'(fs_start), 32'd0);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("c_colour", 32'(c_colour), 32'(e[25:23]));
      chk("c_cx", 32'(c_cx), 32'(e[22:15]));
      chk("c_cy", 32'(c_cy), 32'(e[14:8]));
      chk("c_r", 32'(c_r), 32'(e[7:0]));
    end
    plot_circ();
    if (drop_early) start = 1'b0;
    for (int i = 0; i < lc; i++) begin
      tick();
      chk("c_start_hold", 32'(c_start), 32'd1);
    end
    c_done = 1'b1;
    tick();
    chk("c_start_drop", 32'(c_start), 32'd0);
    chk("done_early", 32'(done), 32'd0);
    for (int i = 0; i < hc; i++) begin
      tick();
      chk("done_relwait", 32'(done), 32'd0);
    end
    c_done = 1'b0;
    tick();
    chk("done_rise", 32'(done), 32'd1);
    chk("err_nominal", 32'(err), 32'd0);
    if (!drop_early) begin
      for (int i = 0; i < hold_done; i++) begin
        tick();
        chk("done_hold", 32'(done), 32'd1);
      end
      start = 1'b0;
    end
    tick();
    chk("done_fall", 32'(done), 32'd0);
    chk("vga_idle", 32'(vga_plot), 32'd0);
  endtask

  // The fillscreen engine never answers: watchdog must abort after TMO cycles
  task automatic timeout_fill();
    int cnt;
    bit saw_c;
    accept(3'($urandom), 8'($urandom), 7'($urandom), 8'($urandom), 1'b0);
    cnt = 1; saw_c = 1'b0;
    while (fs_start && cnt < 100) begin
      tick();
      if (c_start) saw_c = 1'b1;
      if (fs_start) cnt++;
    end
    chk("tmo_fill_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_fill_err", 32'(err), 32'd1);
    chk("tmo_fill_done", 32'(done), 32'd1);
    chk("tmo_no_circle", 32'(saw_c), 32'd0);
    start = 1'b0;
    tick();
    chk("tmo_done_fall", 32'(done), 32'd0);
    chk("tmo_err_hold", 32'(err), 32'd1);
  endtask

  // The circle engine never answers
  task automatic timeout_circ();
    int cnt;
    logic [7:0] r;
    r = 8'($urandom);
    accept(3'd1, 8'd10, 7'd20, r, 1'b0);
    fs_done = 1'b1;
    tick();
    fs_done = 1'b0;
    tick();
    chk("tmo_c_rise", 32'(c_start), 32'd1);
    chk("tmo_c_r", 32'(c_r), 32'(r));
    cnt = 1;
    while (c_start && cnt < 100) begin
      tick();
      if (c_start) cnt++;
    end
    chk("tmo_circ_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_circ_err", 32'(err), 32'd1);
    chk("tmo_circ_done", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    chk("tmo_circ_done_fall", 32'(done), 32'd0);
  endtask

  // Reset asserted while the circle engine is running
  task automatic reset_mid_circ();
    accept(3'd7, 8'd100, 7'd50, 8'd30, 1'b0);
    fs_done = 1'b1;
    tick();
    fs_done = 1'b0;
    tick();
    chk("rst_pre_cstart", 32'(c_start), 32'd1);
    c_x = 8'd3; c_y = 7'd4; c_colour_px = 3'd6; c_plot = 1'b1;
    #1;
    chk("rst_pre_plot", 32'(vga_plot), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_c_start", 32'(c_start), 32'd0);
    chk("rst_fs_start", 32'(fs_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vga_plot", 32'(vga_plot), 32'd0);
    chk("rst_c_r", 32'(c_r), 32'd0);
    chk("rst_c_cx", 32'(c_cx), 32'd0);
    c_plot = 1'b0; start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_fs", 32'(fs_start), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_fs_start", 32'(fs_start), 32'd0);
    chk("reset_c_start", 32'(c_start), 32'd0);
    chk("reset_vga_plot", 32'(vga_plot), 32'd0);
    chk("reset_c_r", 32'(c_r), 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal pass, then argument latching with radius changed mid-fill
    run_pass(3'd2, 8'd80, 7'd60, 8'd40, 3, 4, 1, 1, 1'b0, 1'b0, 2);
    run_pass(3'd2, 8'd80, 7'd60, 8'd40, 2, 2, 0, 0, 1'b0, 1'b1, 0);
    // Early start drop during the circle phase
    run_pass(3'd4, 8'd15, 7'd100, 8'd7, 0, 1, 2, 0, 1'b1, 1'b0, 0);

    // Watchdog aborts, then a normal pass must clear err
    timeout_fill();
    run_pass(3'd3, 8'd20, 7'd30, 8'd5, 1, 1, 0, 1, 1'b0, 1'b0, 1);
    timeout_circ();

    reset_mid_circ();

    // Randomized passes
    for (int n = 0; n < 12; n++) begin
      run_pass(3'($urandom), 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
               8'($urandom), $urandom_range(0, 10), $urandom_range(0, 10),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard limit in case the run wedges
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end of run");
    $fatal(1, "simulation time limit");
  end

endmodule
